vpu_req_queue: RTL and testbench
================================

VPU_REQ_QUEUE -- requirements
Module: vpu_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued-but-unanswered instructions; 1..255.
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- h_valid_i  in  1  host instruction valid.
- h_ready_o  out  1  queue can accept.
- h_opcode_i  in  8  opcode.
- h_dst0_i, h_src0_i, h_src1_i, h_src2_i, h_imm_i  in  24 each  operand fields.
- h_stream_id_i  in  STREAM_ID_WIDTH  stream tag.
- valid_o  out  1  instruction offered to VPU request interface.
- ready_i  in  1  VPU accepts.
- opcode_o  out  8; dst0_o, src0_o, src1_o, src2_o, imm_o  out  24 each; stream_id_o  out  STREAM_ID_WIDTH  head entry fields.
- resp_valid_i  in  1  VPU response valid (snooped).
- resp_ready_i  in  1  host response ready (snooped).
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- outstanding_o  out  8  in-flight count.
- idle_o  out  1  FIFO empty and outstanding zero.
- err_o  out  1  sticky response-underflow flag.
REQ-004 Clock and reset SHALL be the single clock clk and reset rst_n, synchronous, active-low.

Function
REQ-005 Push SHALL occur when h_valid_i && h_ready_o; h_ready_o SHALL equal (count_o != DEPTH), no combinational dependence on ready_i.
REQ-006 Pop (issue) SHALL occur when valid_o && ready_i; valid_o SHALL equal (count_o != 0) && (outstanding_o != MAX_OUTSTANDING).
REQ-007 Output fields SHALL be the head entry, stable while valid_o && !ready_i.
REQ-008 Entry pushed in cycle N SHALL be first visible on valid_o in cycle N+1 (no bypass); FIFO order SHALL be preserved.
REQ-009 Simultaneous push and pop SHALL leave count_o unchanged; push when full SHALL not occur; pop when empty SHALL not occur.
REQ-010 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; full = MSBs differ, lower bits equal.
REQ-011 Response event = resp_valid_i && resp_ready_i; outstanding_o SHALL +1 on issue only, -1 on response only, unchanged on both.
REQ-012 Response event with outstanding_o == 0 and no same-cycle issue SHALL leave outstanding_o at 0 and set err_o, held until reset.
REQ-013 At outstanding_o == MAX_OUTSTANDING, valid_o SHALL deassert next cycle; same-cycle response SHALL restore valid_o the following cycle.
REQ-014 idle_o SHALL be registered-state derived: (count_o == 0) && (outstanding_o == 0).

Reset
REQ-015 With rst_n low at a rising edge: pointers, count_o, outstanding_o, err_o SHALL clear to 0; valid_o 0, h_ready_o 1, idle_o 1 next cycle.
REQ-016 Reset mid-operation SHALL discard all queued and in-flight tracking; FIFO storage need not be cleared, output fields don't-care while valid_o=0.

Configuration
REQ-017 Macro VPU_REQ_QUEUE_PERF_EN defined: SHALL add outputs perf_issue_cnt_o (32b, +1 per issue) and perf_stall_cnt_o (32b, +1 per cycle count_o!=0 && !valid_o-or-!ready_i handshake), both saturating at all-ones, reset to 0.
REQ-018 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-019 STREAM_ID_WIDTH, vpu_h2d_req_opcode_t and vpu_h2d_req_instr_t SHALL come from VPU_PKG; FIFO entry SHALL be a packed struct {vpu_h2d_req_instr_t, stream id} defined in VPU_PKG as vpu_req_queue_entry_t.
REQ-020 Storage SHALL be sub-module vpu_req_fifo (parameterized DEPTH, data width); credit/outstanding logic stays in vpu_req_queue.

Verification
REQ-021 Reset then push 1 entry (opcode 0x01, stream_id 2), ready_i=1 -> valid_o high exactly cycle N+1, fields match, count_o back to 0.
REQ-022 DEPTH=4, ready_i=0, push 5 -> h_ready_o low after 4th, 5th not accepted, count_o=4; release ready_i -> 4 entries out in order.
REQ-023 MAX_OUTSTANDING=2, 3 queued, no responses -> 2 issued, valid_o low, outstanding_o=2; one response -> third issues next cycle.
REQ-024 Issue and response same cycle at outstanding_o=1 -> stays 1; response at outstanding_o=0 -> err_o=1, stays 1 until rst_n.
REQ-025 rst_n low with count_o=3, outstanding_o=2 -> next cycle all zero, idle_o=1, valid_o=0.
REQ-026 With VPU_REQ_QUEUE_PERF_EN: 3 issues plus 5 stalled cycles -> perf_issue_cnt_o=3, perf_stall_cnt_o=5.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU request types: host-to-device instruction layout and the request-queue entry.
package vpu_pkg;

    localparam int STREAM_ID_WIDTH   = 4;
    localparam int OPERAND_WIDTH     = 24;

    typedef logic [7:0]               vpu_h2d_req_opcode_t;
    typedef logic [OPERAND_WIDTH-1:0] vpu_operand_t;

    localparam vpu_h2d_req_opcode_t VPU_OP_NOP   = 8'h00;
    localparam vpu_h2d_req_opcode_t VPU_OP_LOAD  = 8'h01;
    localparam vpu_h2d_req_opcode_t VPU_OP_STORE = 8'h02;
    localparam vpu_h2d_req_opcode_t VPU_OP_MAC   = 8'h10;

    typedef struct packed {
        vpu_h2d_req_opcode_t opcode;
        vpu_operand_t        dst0;
        vpu_operand_t        src0;
        vpu_operand_t        src1;
        vpu_operand_t        src2;
        vpu_operand_t        imm;
    } vpu_h2d_req_instr_t;

    typedef struct packed {
        vpu_h2d_req_instr_t         instr;
        logic [STREAM_ID_WIDTH-1:0] stream_id;
    } vpu_req_queue_entry_t;

    localparam int VPU_REQ_ENTRY_WIDTH = $bits(vpu_req_queue_entry_t);

endpackage

// File: rtl/vpu_req_fifo.sv
// Instruction storage for vpu_req_queue: pointer-based FIFO, head entry read without a register stage.
module vpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vpu_req_queue.sv
// VPU request queue: host instruction FIFO with outstanding-request credit tracking.
// Optional performance counters are enabled by defining VPU_REQ_QUEUE_PERF_EN.
module vpu_req_queue
    import vpu_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       h_valid_i,
    output logic                       h_ready_o,
    input  logic [7:0]                 h_opcode_i,
    input  logic [23:0]                h_dst0_i,
    input  logic [23:0]                h_src0_i,
    input  logic [23:0]                h_src1_i,
    input  logic [23:0]                h_src2_i,
    input  logic [23:0]                h_imm_i,
    input  logic [STREAM_ID_WIDTH-1:0] h_stream_id_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [7:0]                 opcode_o,
    output logic [23:0]                dst0_o,
    output logic [23:0]                src0_o,
    output logic [23:0]                src1_o,
    output logic [23:0]                src2_o,
    output logic [23:0]                imm_o,
    output logic [STREAM_ID_WIDTH-1:0] stream_id_o,
    input  logic                       resp_valid_i,
    input  logic                       resp_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [7:0]                 outstanding_o,
    output logic                       idle_o,
    output logic                       err_o
`ifdef VPU_REQ_QUEUE_PERF_EN
    ,
    output logic [31:0]                perf_issue_cnt_o,
    output logic [31:0]                perf_stall_cnt_o
`endif
);

    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    vpu_req_queue_entry_t wr_entry;
    vpu_req_queue_entry_t head_entry;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue;
    logic                 resp;
    logic [7:0]           outstanding_reg;
    logic [7:0]           outstanding_next;
    logic                 err_reg;
    logic                 err_next;

    always_comb begin
        wr_entry                 = '0;
        wr_entry.instr.opcode    = h_opcode_i;
        wr_entry.instr.dst0      = h_dst0_i;
        wr_entry.instr.src0      = h_src0_i;
        wr_entry.instr.src1      = h_src1_i;
        wr_entry.instr.src2      = h_src2_i;
        wr_entry.instr.imm       = h_imm_i;
        wr_entry.stream_id       = h_stream_id_i;
    end

    vpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VPU_REQ_ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (h_valid_i),
        .wr_data (wr_entry),
        .pop     (issue),
        .rd_data (head_entry),
        .count   (count_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Both handshakes depend only on registered state, never on ready_i or the host valid.
    assign h_ready_o = !fifo_full;
    assign valid_o   = !fifo_empty && (outstanding_reg != MAX_OUT);
    assign issue     = valid_o && ready_i;
    assign resp      = resp_valid_i && resp_ready_i;

    assign opcode_o    = head_entry.instr.opcode;
    assign dst0_o      = head_entry.instr.dst0;
    assign src0_o      = head_entry.instr.src0;
    assign src1_o      = head_entry.instr.src1;
    assign src2_o      = head_entry.instr.src2;
    assign imm_o       = head_entry.instr.imm;
    assign stream_id_o = head_entry.stream_id;

    // A response with nothing in flight is a protocol error; the count is clamped at zero.
    always_comb begin
        outstanding_next = outstanding_reg;
        err_next         = err_reg;
        if (issue && !resp) begin
            outstanding_next = outstanding_reg + 8'd1;
        end else if (!issue && resp) begin
            if (outstanding_reg == 8'd0) begin
                err_next = 1'b1;
            end else begin
                outstanding_next = outstanding_reg - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_reg <= 8'd0;
            err_reg         <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            err_reg         <= err_next;
        end
    end

    assign outstanding_o = outstanding_reg;
    assign err_o         = err_reg;
    assign idle_o        = fifo_empty && (outstanding_reg == 8'd0);

`ifdef VPU_REQ_QUEUE_PERF_EN
    logic [31:0] perf_issue_reg;
    logic [31:0] perf_stall_reg;

    // A stall is any cycle with queued work that does not complete an issue handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (issue && (perf_issue_reg != '1)) begin
                perf_issue_reg <= perf_issue_reg + 32'd1;
            end
            if (!fifo_empty && !issue && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_issue_cnt_o = perf_issue_reg;
    assign perf_stall_cnt_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_vpu_req_queue.sv
// Randomized self-checking bench for vpu_req_queue against a queue-based reference model.
module tb_vpu_req_queue;
    import vpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       h_valid = 1'b0;
    logic                       h_ready;
    logic [7:0]                 h_opcode = '0;
    logic [23:0]                h_dst0 = '0, h_src0 = '0, h_src1 = '0, h_src2 = '0, h_imm = '0;
    logic [STREAM_ID_WIDTH-1:0] h_stream_id = '0;
    logic                       valid;
    logic                       ready = 1'b0;
    logic [7:0]                 opcode;
    logic [23:0]                dst0, src0, src1, src2, imm;
    logic [STREAM_ID_WIDTH-1:0] stream_id;
    logic                       resp_valid = 1'b0;
    logic                       resp_ready = 1'b0;
    logic [CW-1:0]              count;
    logic [7:0]                 outstanding;
    logic                       idle;
    logic                       err;
`ifdef VPU_REQ_QUEUE_PERF_EN
    logic [31:0]                perf_issue_cnt;
    logic [31:0]                perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    vpu_req_queue_entry_t mq[$];
    int                   m_out = 0;
    bit                   m_err = 1'b0;
    int unsigned          m_issues = 0;
    int unsigned          m_stalls = 0;

    vpu_req_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk), .rst_n (rst_n),
        .h_valid_i (h_valid), .h_ready_o (h_ready), .h_opcode_i (h_opcode),
        .h_dst0_i (h_dst0), .h_src0_i (h_src0), .h_src1_i (h_src1), .h_src2_i (h_src2),
        .h_imm_i (h_imm), .h_stream_id_i (h_stream_id),
        .valid_o (valid), .ready_i (ready), .opcode_o (opcode),
        .dst0_o (dst0), .src0_o (src0), .src1_o (src1), .src2_o (src2), .imm_o (imm),
        .stream_id_o (stream_id),
        .resp_valid_i (resp_valid), .resp_ready_i (resp_ready),
        .count_o (count), .outstanding_o (outstanding), .idle_o (idle), .err_o (err)
`ifdef VPU_REQ_QUEUE_PERF_EN
        , .perf_issue_cnt_o (perf_issue_cnt), .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    function automatic vpu_req_queue_entry_t rand_entry(input logic [7:0] op, input logic [STREAM_ID_WIDTH-1:0] sid);
        vpu_req_queue_entry_t e;
        e.instr.opcode = op;
        e.instr.dst0   = 24'($urandom);
        e.instr.src0   = 24'($urandom);
        e.instr.src1   = 24'($urandom);
        e.instr.src2   = 24'($urandom);
        e.instr.imm    = 24'($urandom);
        e.stream_id    = sid;
        return e;
    endfunction

    function automatic vpu_req_queue_entry_t dut_head();
        vpu_req_queue_entry_t e;
        e.instr.opcode = opcode;
        e.instr.dst0   = dst0;
        e.instr.src0   = src0;
        e.instr.src1   = src1;
        e.instr.src2   = src2;
        e.instr.imm    = imm;
        e.stream_id    = stream_id;
        return e;
    endfunction

    // One clock: drive inputs at negedge, advance the model at posedge, return at the next negedge.
    task automatic tick(input bit rst, input bit hv, input vpu_req_queue_entry_t e,
                        input bit rdy, input bit rv, input bit rr);
        bit m_valid, m_issue, m_push, m_resp;
        rst_n = !rst; h_valid = hv;
        h_opcode = e.instr.opcode; h_dst0 = e.instr.dst0; h_src0 = e.instr.src0;
        h_src1 = e.instr.src1; h_src2 = e.instr.src2; h_imm = e.instr.imm; h_stream_id = e.stream_id;
        ready = rdy; resp_valid = rv; resp_ready = rr;
        m_valid = (mq.size() != 0) && (m_out < MAXO);
        m_issue = m_valid && rdy;
        m_push  = hv && (mq.size() < DEPTH);
        m_resp  = rv && rr;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_out = 0; m_err = 1'b0; m_issues = 0; m_stalls = 0;
        end else begin
            if (m_issue) m_issues++;
            if (mq.size() != 0 && !m_issue) m_stalls++;
            if (m_issue) void'(mq.pop_front());
            if (m_push) mq.push_back(e);
            if (m_issue && !m_resp) m_out++;
            else if (m_resp && !m_issue) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        vpu_req_queue_entry_t z = '0;
        tick(1, 0, z, 0, 0, 0);
        tick(1, 0, z, 0, 0, 0);
        n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_vec++; if (h_ready !== 1'b1) begin n_bad++; $display("FAIL reset_h_ready: got %0b want 1", h_ready); end
        n_vec++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
        n_vec++; if (count !== '0 || outstanding !== 8'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_state: got count=%0d out=%0d err=%0b want 0/0/0", count, outstanding, err); end
`ifdef VPU_REQ_QUEUE_PERF_EN
        n_vec++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_issue_cnt, perf_stall_cnt); end
`endif
        $display("reset: count=%0d outstanding=%0d idle=%0b", count, outstanding, idle);
    endtask

    task automatic test_single();
        vpu_req_queue_entry_t z = '0;
        vpu_req_queue_entry_t e = rand_entry(8'h01, 4'd2);
        tick(0, 1, e, 1, 0, 0);
        n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_n1: got %0b want 1", valid); end
        n_vec++; if (dut_head() !== e) begin n_bad++; $display("FAIL single_fields: got %h want %h", dut_head(), e); end
        tick(0, 0, z, 1, 0, 0);
        n_vec++; if (count !== '0 || valid !== 1'b0 || outstanding !== 8'd1) begin
            n_bad++; $display("FAIL single_after_issue: got count=%0d valid=%0b out=%0d want 0/0/1", count, valid, outstanding); end
        tick(0, 0, z, 0, 1, 1);
        n_vec++; if (outstanding !== 8'd0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL single_resp: got out=%0d idle=%0b want 0/1", outstanding, idle); end
        $display("single: opcode=%h stream=%0d issued", e.instr.opcode, e.stream_id);
    endtask

    task automatic test_full();
        vpu_req_queue_entry_t z = '0;
        vpu_req_queue_entry_t exp_e [5];
        for (int i = 0; i < 5; i++) begin
            exp_e[i] = rand_entry(8'(8'h20 + i), 4'(i));
            n_vec++; if (h_ready !== (i < DEPTH)) begin
                n_bad++; $display("FAIL full_h_ready_%0d: got %0b want %0b", i, h_ready, (i < DEPTH)); end
            tick(0, 1, exp_e[i], 0, 0, 0);
        end
        n_vec++; if (count !== CW'(DEPTH) || h_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_count: got count=%0d h_ready=%0b want %0d/0", count, h_ready, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (valid !== 1'b1 || dut_head() !== exp_e[i]) begin
                n_bad++; $display("FAIL full_order_%0d: got valid=%0b %h want 1 %h", i, valid, dut_head(), exp_e[i]); end
            tick(0, 0, z, 1, 1, 1);
        end
        n_vec++; if (count !== '0 || outstanding !== 8'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL full_drain: got count=%0d out=%0d err=%0b want 0/0/0", count, outstanding, err); end
        $display("full: %0d accepted of 5, drained in order", DEPTH);
    endtask

    task automatic test_credit();
        vpu_req_queue_entry_t z = '0;
        vpu_req_queue_entry_t e [3];
        for (int i = 0; i < 3; i++) begin
            e[i] = rand_entry(8'(8'h40 + i), 4'(i + 5));
            tick(0, 1, e[i], 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, z, 1, 0, 0);
        n_vec++; if (outstanding !== 8'(MAXO) || valid !== 1'b0 || count !== CW'(1)) begin
            n_bad++; $display("FAIL credit_block: got out=%0d valid=%0b count=%0d want %0d/0/1", outstanding, valid, count, MAXO); end
        tick(0, 0, z, 1, 1, 1);
        n_vec++; if (valid !== 1'b1 || outstanding !== 8'(MAXO - 1) || dut_head() !== e[2]) begin
            n_bad++; $display("FAIL credit_restore: got valid=%0b out=%0d want 1/%0d", valid, outstanding, MAXO - 1); end
        tick(0, 0, z, 1, 0, 0);
        n_vec++; if (count !== '0 || outstanding !== 8'(MAXO)) begin
            n_bad++; $display("FAIL credit_third: got count=%0d out=%0d want 0/%0d", count, outstanding, MAXO); end
        tick(0, 0, z, 0, 1, 1);
        tick(0, 0, z, 0, 1, 1);
        $display("credit: 3 queued, blocked at %0d, third issued after response", MAXO);
    endtask

    task automatic test_err();
        vpu_req_queue_entry_t z = '0;
        tick(0, 1, rand_entry(8'h10, 4'd1), 0, 0, 0);
        tick(0, 0, z, 1, 0, 0);
        tick(0, 1, rand_entry(8'h11, 4'd3), 0, 0, 0);
        tick(0, 0, z, 1, 1, 1);
        n_vec++; if (outstanding !== 8'd1 || count !== '0) begin
            n_bad++; $display("FAIL err_issue_resp: got out=%0d count=%0d want 1/0", outstanding, count); end
        tick(0, 0, z, 0, 1, 1);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_early: got %0b want 0", err); end
        tick(0, 0, z, 0, 1, 1);
        n_vec++; if (err !== 1'b1 || outstanding !== 8'd0) begin
            n_bad++; $display("FAIL err_set: got err=%0b out=%0d want 1/0", err, outstanding); end
        tick(0, 0, z, 0, 0, 0);
        tick(0, 0, z, 0, 0, 0);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", err); end
        tick(1, 0, z, 0, 0, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0b want 0", err); end
        $display("err: underflow flagged, held, cleared by reset");
    endtask

    task automatic test_mid_reset();
        vpu_req_queue_entry_t z = '0;
        for (int i = 0; i < DEPTH; i++) tick(0, 1, rand_entry(8'(i), 4'(i)), 0, 0, 0);
        tick(0, 0, z, 1, 0, 0);
        tick(0, 1, rand_entry(8'h77, 4'd7), 1, 0, 0);
        n_vec++; if (count !== CW'(3) || outstanding !== 8'd2) begin
            n_bad++; $display("FAIL midrst_setup: got count=%0d out=%0d want 3/2", count, outstanding); end
        tick(1, 0, z, 0, 0, 0);
        n_vec++; if (count !== '0 || outstanding !== 8'd0 || idle !== 1'b1 || valid !== 1'b0 || h_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_clear: got count=%0d out=%0d idle=%0b valid=%0b h_ready=%0b want 0/0/1/0/1",
                              count, outstanding, idle, valid, h_ready); end
        $display("mid_reset: queue and credits discarded");
    endtask

`ifdef VPU_REQ_QUEUE_PERF_EN
    task automatic test_perf();
        vpu_req_queue_entry_t z = '0;
        tick(1, 0, z, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, rand_entry(8'(8'h60 + i), 4'(i)), 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, z, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, z, 1, 1, 1);
        n_vec++; if (perf_issue_cnt !== 32'd3 || perf_stall_cnt !== 32'd5) begin
            n_bad++; $display("FAIL perf_counts: got issue=%0d stall=%0d want 3/5", perf_issue_cnt, perf_stall_cnt); end
        $display("perf: issue=%0d stall=%0d", perf_issue_cnt, perf_stall_cnt);
    endtask
`endif

    task automatic test_random();
        bit rst, hv, rdy, rv, rr;
        tick(1, 0, '0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            hv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 4) < 2);
            rr  = ($urandom_range(0, 3) != 0);
            tick(rst, hv, rand_entry(8'($urandom), 4'($urandom)), rdy, rv, rr);
            n_vec++;
            if (count !== CW'(mq.size()) || outstanding !== 8'(m_out) || err !== m_err ||
                valid !== ((mq.size() != 0) && (m_out < MAXO)) || h_ready !== (mq.size() < DEPTH) ||
                idle !== ((mq.size() == 0) && (m_out == 0))) begin
                n_bad++;
                $display("FAIL rand_state_%0d: got count=%0d out=%0d err=%0b valid=%0b h_ready=%0b idle=%0b want count=%0d out=%0d err=%0b",
                         c, count, outstanding, err, valid, h_ready, idle, mq.size(), m_out, m_err);
            end
            if (mq.size() != 0) begin
                n_vec++;
                if (dut_head() !== mq[0]) begin
                    n_bad++; $display("FAIL rand_head_%0d: got %h want %h", c, dut_head(), mq[0]);
                end
            end
`ifdef VPU_REQ_QUEUE_PERF_EN
            n_vec++;
            if (perf_issue_cnt !== m_issues || perf_stall_cnt !== m_stalls) begin
                n_bad++; $display("FAIL rand_perf_%0d: got %0d/%0d want %0d/%0d", c, perf_issue_cnt, perf_stall_cnt, m_issues, m_stalls);
            end
`endif
        end
        $display("random: 400 cycles, queue=%0d outstanding=%0d err=%0b", mq.size(), m_out, m_err);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_credit();
        test_err();
        test_mid_reset();
`ifdef VPU_REQ_QUEUE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
